// File: rtl/doodle_fall_pkg.sv
// Shared definitions for the platform spawn logic.
//   HPOS_W   : width of a horizontal position
//   HBP      : lowest legal hpos (horizontal back porch offset)
//   RANGE    : number of legal hpos values starting at HBP
//   HPOS_MAX : highest legal hpos
//   state_t  : scheduler FSM states
//   abs_diff : unsigned |a-b| with one extra bit so it never wraps
package doodle_fall_pkg;

    localparam int HPOS_W   = 10;
    localparam int HBP      = 325;
    localparam int RANGE    = 225;
    localparam int HPOS_MAX = HBP + RANGE - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic logic [HPOS_W:0] abs_diff(input logic [HPOS_W-1:0] a,
                                                 input logic [HPOS_W-1:0] b);
        logic [HPOS_W:0] ea;
        logic [HPOS_W:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   req : request vector, one bit per slot
//   ptr : slot with highest priority this round
//   gnt : one-hot winner (all zero when req is zero)
//   idx : index of the winner (0 when req is zero)
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic found;
    int   k;

    // Scan slots in priority order ptr, ptr+1, ... wrapping; first hit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = IDX_W'(k);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign gnt[gi] = found && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/platform_spawn_scheduler.sv
// Shares one random horizontal-position source among N_SLOTS platform slots.
// Requests are served round-robin; a candidate is rejected when it is out of
// the legal window or closer than MIN_SEP to the last granted position. After
// MAX_RETRY rejections a deterministic fallback position is forced. Each grant
// is followed by GAP_CYCLES idle cycles so the next service sees fresh data.
//   clk        : system clock
//   rst        : asynchronous, active-high reset
//   rand_hpos  : current generator output
//   req        : level request per slot, held until granted
//   grant      : one-hot, single-cycle grant pulse
//   grant_hpos : position for the granted slot (holds between grants)
//   busy       : high whenever a service is in progress
module platform_spawn_scheduler
    import doodle_fall_pkg::*;
#(
    parameter int N_SLOTS    = 4,
    parameter int MIN_SEP    = 40,
    parameter int GAP_CYCLES = 3,
    parameter int MAX_RETRY  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HPOS_W-1:0] rand_hpos,
    input  logic [N_SLOTS-1:0] req,
    output logic [N_SLOTS-1:0] grant,
    output logic [HPOS_W-1:0] grant_hpos,
    output logic              busy
);

    localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int RET_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [HPOS_W-1:0] HBP_V     = HPOS_W'(HBP);
    localparam logic [HPOS_W-1:0] HMAX_V    = HPOS_W'(HPOS_MAX);
    localparam logic [HPOS_W-1:0] MID_V     = HPOS_W'(HBP + RANGE / 2);
    localparam logic [HPOS_W:0]   SEP_WIDE  = (HPOS_W + 1)'(MIN_SEP);
    localparam logic [HPOS_W:0]   HMAX_WIDE = (HPOS_W + 1)'(HPOS_MAX);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   slot_reg, slot_next;
    logic [N_SLOTS-1:0] slot_oh_reg, slot_oh_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [RET_W-1:0]   retry_reg, retry_next;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [HPOS_W-1:0]  last_hpos_reg, last_hpos_next;
    logic [N_SLOTS-1:0] grant_reg, grant_next;
    logic [HPOS_W-1:0]  grant_hpos_reg, grant_hpos_next;

    logic [N_SLOTS-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;

    logic               in_range;
    logic               accept;
    logic [HPOS_W:0]    fb_up;
    logic [HPOS_W-1:0]  fallback;
    logic [HPOS_W-1:0]  cand;

    rr_arbiter #(
        .N     (N_SLOTS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (req),
        .ptr (rr_ptr_reg),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign in_range = (rand_hpos >= HBP_V) && (rand_hpos <= HMAX_V);
    assign accept   = in_range && (abs_diff(rand_hpos, last_hpos_reg) >= SEP_WIDE);

    // Fallback steps MIN_SEP away from the last position, upward when it fits.
    assign fb_up    = {1'b0, last_hpos_reg} + SEP_WIDE;
    assign fallback = (fb_up <= HMAX_WIDE) ? fb_up[HPOS_W-1:0]
                                           : last_hpos_reg - HPOS_W'(MIN_SEP);
    assign cand     = accept ? rand_hpos : fallback;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            slot_reg       <= '0;
            slot_oh_reg    <= '0;
            rr_ptr_reg     <= '0;
            retry_reg      <= '0;
            gap_cnt_reg    <= '0;
            last_hpos_reg  <= MID_V;
            grant_reg      <= '0;
            grant_hpos_reg <= HBP_V;
        end else begin
            state_reg      <= state_next;
            slot_reg       <= slot_next;
            slot_oh_reg    <= slot_oh_next;
            rr_ptr_reg     <= rr_ptr_next;
            retry_reg      <= retry_next;
            gap_cnt_reg    <= gap_cnt_next;
            last_hpos_reg  <= last_hpos_next;
            grant_reg      <= grant_next;
            grant_hpos_reg <= grant_hpos_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        slot_next       = slot_reg;
        slot_oh_next    = slot_oh_reg;
        rr_ptr_next     = rr_ptr_reg;
        retry_next      = retry_reg;
        gap_cnt_next    = gap_cnt_reg;
        last_hpos_next  = last_hpos_reg;
        grant_next      = '0;   // grant is a single-cycle pulse
        grant_hpos_next = grant_hpos_reg;

        case (state_reg)
            ST_IDLE: begin
                // The winner is committed here; later req changes do not matter.
                if (|req) begin
                    slot_next    = arb_idx;
                    slot_oh_next = arb_gnt;
                    retry_next   = '0;
                    state_next   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (accept || (retry_reg == RET_W'(MAX_RETRY))) begin
                    grant_next      = slot_oh_reg;
                    grant_hpos_next = cand;
                    last_hpos_next  = cand;
                    rr_ptr_next     = (slot_reg == IDX_W'(N_SLOTS - 1)) ? '0
                                                                        : slot_reg + 1'b1;
                    gap_cnt_next    = GAP_W'(GAP_CYCLES - 1);
                    state_next      = ST_GAP;
                end else begin
                    retry_next = retry_reg + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign grant      = grant_reg;
    assign grant_hpos = grant_hpos_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_platform_spawn_scheduler.sv
module tb_platform_spawn_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] rand_hpos;
    logic [3:0] req;
    logic [3:0] grant;
    logic [9:0] grant_hpos;
    logic       busy;

    int total = 0;
    int bad   = 0;

    platform_spawn_scheduler #(
        .N_SLOTS    (4),
        .MIN_SEP    (40),
        .GAP_CYCLES (3),
        .MAX_RETRY  (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rand_hpos  (rand_hpos),
        .req        (req),
        .grant      (grant),
        .grant_hpos (grant_hpos),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until a grant pulse is seen or the budget runs out.
    task automatic wait_grant(input int max_cycles, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (grant == 4'b0000 && n < max_cycles);
        $display("txn: grant=%b hpos=%0d after %0d cycles", grant, grant_hpos, n);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL wait_idle: busy=%b want=0 after %0d cycles", busy, n);
        end
    endtask

    task automatic test_reset_state();
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
        total++; if (grant_hpos !== 10'd325) begin bad++; $display("FAIL reset_hpos: got %0d want 325", grant_hpos); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    // Async reset mid-service, then first grant measured against the 437 reset value.
    task automatic test_reset();
        int n;
        req = 4'b0001; rand_hpos = 10'd420;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rst_async_grant: got %b want 0000", grant); end
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        tick();
        rand_hpos = 10'd397;
        wait_grant(12, n);
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL first_grant: got %b want 0001", grant); end
        total++; if (grant_hpos !== 10'd397) begin bad++; $display("FAIL first_hpos: got %0d want 397", grant_hpos); end
        total++; if (n !== 1) begin bad++; $display("FAIL first_latency: got %0d want 1", n); end
        req = 4'b0000;
        tick();
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL first_width: got %b want 0000", grant); end
        total++; if (grant_hpos !== 10'd397) begin bad++; $display("FAIL first_hold: got %0d want 397", grant_hpos); end
        wait_idle();
    endtask

    task automatic test_out_of_range();
        int n;
        req = 4'b0100; rand_hpos = 10'd600;
        tick(); tick(); tick();
        rand_hpos = 10'd500;
        wait_grant(12, n);
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL oor_grant: got %b want 0100", grant); end
        total++; if (grant_hpos !== 10'd500) begin bad++; $display("FAIL oor_hpos: got %0d want 500", grant_hpos); end
        total++; if (n !== 1) begin bad++; $display("FAIL oor_latency: got %0d want 1", n); end
        req = 4'b0000;
        tick();
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL oor_width: got %b want 0000", grant); end
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL gap_busy: got %b want 1", busy); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL gap_end: got %b want 0", busy); end
    endtask

    task automatic test_fallback();
        int n;
        req = 4'b0001; rand_hpos = 10'd510;
        wait_grant(20, n);
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL fb_up_grant: got %b want 0001", grant); end
        total++; if (grant_hpos !== 10'd540) begin bad++; $display("FAIL fb_up_hpos: got %0d want 540", grant_hpos); end
        total++; if (n !== 9) begin bad++; $display("FAIL fb_up_latency: got %0d want 9", n); end
        req = 4'b0000;
        wait_idle();
        req = 4'b0010; rand_hpos = 10'd545;
        tick();
        req = 4'b0000;   // dropped during CHECK: grant must still be issued
        wait_grant(20, n);
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL fb_dn_grant: got %b want 0010", grant); end
        total++; if (grant_hpos !== 10'd500) begin bad++; $display("FAIL fb_dn_hpos: got %0d want 500", grant_hpos); end
        total++; if (n !== 8) begin bad++; $display("FAIL fb_dn_latency: got %0d want 8", n); end
        wait_idle();
    endtask

    // rr_ptr is 2 on entry, so service order is slot 2,3,0,1.
    task automatic test_back_to_back();
        logic [3:0] exp_g [4];
        logic [9:0] rv    [4];
        int n;
        exp_g[0] = 4'b0100; exp_g[1] = 4'b1000; exp_g[2] = 4'b0001; exp_g[3] = 4'b0010;
        rv[0] = 10'd340; rv[1] = 10'd400; rv[2] = 10'd460; rv[3] = 10'd520;
        req = 4'b1111; rand_hpos = rv[0];
        wait_grant(20, n);
        total++; if (n !== 2) begin bad++; $display("FAIL b2b_first_latency: got %0d want 2", n); end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                total++; if (n + 1 !== 5) begin bad++; $display("FAIL b2b_spacing%0d: got %0d want 5", k, n + 1); end
            end
            total++; if (grant !== exp_g[k]) begin bad++; $display("FAIL b2b_grant%0d: got %b want %b", k, grant, exp_g[k]); end
            total++; if (grant_hpos !== rv[k]) begin bad++; $display("FAIL b2b_hpos%0d: got %0d want %0d", k, grant_hpos, rv[k]); end
            req = req & ~exp_g[k];
            if (k < 3) rand_hpos = rv[k + 1];
            tick();
            total++; if (grant !== 4'b0000) begin bad++; $display("FAIL b2b_width%0d: got %b want 0000", k, grant); end
            if (k < 3) wait_grant(20, n);
        end
        wait_idle();
    endtask

    task automatic test_wrap();
        int n;
        req = 4'b1000; rand_hpos = 10'd400;
        wait_grant(20, n);
        total++; if (grant !== 4'b1000) begin bad++; $display("FAIL wrap_a: got %b want 1000", grant); end
        req = 4'b1001; rand_hpos = 10'd460;
        wait_grant(20, n);
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL wrap_b: got %b want 0001", grant); end
        total++; if (grant_hpos !== 10'd460) begin bad++; $display("FAIL wrap_b_hpos: got %0d want 460", grant_hpos); end
        req = 4'b1000; rand_hpos = 10'd520;
        wait_grant(20, n);
        total++; if (grant !== 4'b1000) begin bad++; $display("FAIL wrap_c: got %b want 1000", grant); end
        req = 4'b0000;
        wait_idle();
    endtask

    // Reset while slot 3 is in CHECK with rr_ptr=3; afterwards slot 1 must win from ptr 0.
    task automatic test_reset_in_check();
        int n;
        req = 4'b0100; rand_hpos = 10'd340;
        wait_grant(20, n);
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL ric_pre: got %b want 0100", grant); end
        req = 4'b0000;
        wait_idle();
        req = 4'b1010; rand_hpos = 10'd600;
        tick(); tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ric_busy: got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ric_async_busy: got %b want 0", busy); end
        total++; if (grant_hpos !== 10'd325) begin bad++; $display("FAIL ric_async_hpos: got %0d want 325", grant_hpos); end
        @(posedge clk); #1;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL ric_rst_grant: got %b want 0000", grant); end
        @(posedge clk); #1;
        rst = 1'b0; rand_hpos = 10'd450;
        tick(); tick();
        rand_hpos = 10'd487;
        wait_grant(12, n);
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL ric_grant: got %b want 0010", grant); end
        total++; if (grant_hpos !== 10'd487) begin bad++; $display("FAIL ric_hpos: got %0d want 487", grant_hpos); end
        total++; if (n !== 1) begin bad++; $display("FAIL ric_latency: got %0d want 1", n); end
        req = 4'b0000;
        wait_idle();
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; rand_hpos = 10'd0;
        repeat (3) tick();
        test_reset_state();
        rst = 1'b0;
        tick();
        test_reset();
        test_out_of_range();
        test_fallback();
        test_back_to_back();
        test_wrap();
        test_reset_in_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
